// File: rtl/srff_bank.sv
// srff_bank: WIDTH independent flip-flops sharing clock, async reset and a
// run-time selectable mode (SR, JK, D, T). SR-illegal inputs (S=R=1) hold
// state and raise a sticky per-channel error flag. All outputs are registered;
// qb is registered next to q rather than derived from it combinationally.
module srff_bank #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] err,
    output logic             chg
);

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    // Next state of one channel given the mode, its two inputs and current q.
    function automatic logic ff_next(
        input logic [1:0] m,
        input logic       x,
        input logic       y,
        input logic       cur
    );
        logic nxt;
        case (m)
            MODE_SR: begin
                case ({x, y})
                    2'b01:   nxt = 1'b0;
                    2'b10:   nxt = 1'b1;
                    default: nxt = cur;   // 00 hold, 11 illegal -> hold
                endcase
            end
            MODE_JK: begin
                case ({x, y})
                    2'b01:   nxt = 1'b0;
                    2'b10:   nxt = 1'b1;
                    2'b11:   nxt = ~cur;
                    default: nxt = cur;
                endcase
            end
            MODE_D:  nxt = x;
            MODE_T:  nxt = x ? ~cur : cur;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] qb_r;
    logic [WIDTH-1:0] err_r;
    logic             chg_r;

    logic [WIDTH-1:0] q_next_s;
    logic [WIDTH-1:0] illegal_s;
    logic [WIDTH-1:0] err_next_s;
    logic             chg_next_s;

    // Compute next q, new SR-illegal events, next err and next change pulse.
    always_comb begin
        q_next_s  = q_r;
        illegal_s = {WIDTH{1'b0}};
        if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                q_next_s[i] = ff_next(mode, a[i], b[i], q_r[i]);
            end
            if (mode == MODE_SR) begin
                illegal_s = a & b;
            end else begin
                illegal_s = {WIDTH{1'b0}};
            end
        end else begin
            q_next_s  = q_r;
            illegal_s = {WIDTH{1'b0}};
        end
        // Clear first, then OR in new events so a same-edge set wins.
        err_next_s = (err_r & ~{WIDTH{err_clr}}) | illegal_s;
        chg_next_s = en & (q_next_s != q_r);
    end

    // State registers; asynchronous reset overrides any same-edge update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r   <= RESET_VAL;
            qb_r  <= ~RESET_VAL;
            err_r <= {WIDTH{1'b0}};
            chg_r <= 1'b0;
        end else begin
            q_r   <= q_next_s;
            qb_r  <= ~q_next_s;
            err_r <= err_next_s;
            chg_r <= chg_next_s;
        end
    end

    assign q   = q_r;
    assign qb  = qb_r;
    assign err = err_r;
    assign chg = chg_r;

endmodule

// File: tb/tb_srff_bank.sv
// Bench for srff_bank: directed vector table, hand-written async-reset
// sequence, then randomized traffic checked against a mask-arithmetic model.
module tb_srff_bank;

    localparam int         W   = 8;
    localparam logic [7:0] RV  = 8'hA5;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         err_clr;
    logic [W-1:0] q;
    logic [W-1:0] qb;
    logic [W-1:0] err;
    logic         chg;

    int tests;
    int fails;

    // reference model state
    logic [7:0] m_q;
    logic [7:0] m_err;
    logic       m_chg;

    srff_bank #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .a       (a),
        .b       (b),
        .err_clr (err_clr),
        .q       (q),
        .qb      (qb),
        .err     (err),
        .chg     (chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [7:0] a;
        logic [7:0] b;
        logic       clr;
        logic [7:0] exp_q;
        logic [7:0] exp_err;
        logic       exp_chg;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q   = RV;
        m_err = 8'h00;
        m_chg = 1'b0;
    endtask

    // Whole-vector model: set/clear/toggle masks per mode.
    task automatic model_update();
        logic [7:0] nq;
        logic [7:0] set_m;
        logic [7:0] clr_m;
        logic [7:0] ill;
        set_m = a & ~b;
        clr_m = b & ~a;
        ill   = 8'h00;
        if (!en) begin
            nq = m_q;
        end else begin
            case (mode)
                2'd0: begin
                    nq  = (m_q | set_m) & ~clr_m;
                    ill = a & b;
                end
                2'd1:    nq = ((m_q | set_m) & ~clr_m) ^ (a & b);
                2'd2:    nq = a;
                default: nq = m_q ^ a;
            endcase
        end
        m_err = (err_clr ? 8'h00 : m_err) | ill;
        m_chg = en && (nq != m_q);
        m_q   = nq;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_update();
        #1;
    endtask

    task automatic drive(input logic e, input logic [1:0] m, input logic [7:0] av,
                         input logic [7:0] bv, input logic c);
        @(negedge clk);
        en = e; mode = m; a = av; b = bv; err_clr = c;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".q"},   q,   m_q);
        check({tag, ".qb"},  qb,  ~m_q);
        check({tag, ".err"}, err, m_err);
        check({tag, ".chg"}, {7'd0, chg}, {7'd0, m_chg});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        en = 1'b0; mode = 2'd0; a = 8'h00; b = 8'h00; err_clr = 1'b0;
        model_reset();

        // reset asserted between edges, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst.q",   q,   8'hA5);
        check("rst.qb",  qb,  8'h5A);
        check("rst.err", err, 8'h00);
        check("rst.chg", {7'd0, chg}, 8'h00);
        // held through an edge while rst_n low
        @(posedge clk); #1;
        check("rst_hold.q", q, 8'hA5);
        @(negedge clk);
        rst_n = 1'b1;

        //          en    mode   a      b      clr   q      err    chg
        vecs[0]  = '{1'b1, 2'd2, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[1]  = '{1'b1, 2'd0, 8'h0F, 8'hF0, 1'b0, 8'h0F, 8'h00, 1'b1};
        vecs[2]  = '{1'b1, 2'd0, 8'h81, 8'h81, 1'b0, 8'h0F, 8'h81, 1'b0};
        vecs[3]  = '{1'b1, 2'd0, 8'h01, 8'h01, 1'b1, 8'h0F, 8'h01, 1'b0};
        vecs[4]  = '{1'b1, 2'd1, 8'hFF, 8'hFF, 1'b0, 8'hF0, 8'h01, 1'b1};
        vecs[5]  = '{1'b1, 2'd1, 8'hFF, 8'hFF, 1'b0, 8'h0F, 8'h01, 1'b1};
        vecs[6]  = '{1'b1, 2'd2, 8'h3C, 8'h00, 1'b0, 8'h3C, 8'h01, 1'b1};
        vecs[7]  = '{1'b1, 2'd3, 8'h01, 8'h00, 1'b0, 8'h3D, 8'h01, 1'b1};
        vecs[8]  = '{1'b1, 2'd3, 8'h01, 8'h00, 1'b0, 8'h3C, 8'h01, 1'b1};
        vecs[9]  = '{1'b1, 2'd3, 8'h01, 8'h00, 1'b0, 8'h3D, 8'h01, 1'b1};
        vecs[10] = '{1'b0, 2'd2, 8'hFF, 8'h00, 1'b0, 8'h3D, 8'h01, 1'b0};
        vecs[11] = '{1'b0, 2'd2, 8'hFF, 8'h00, 1'b1, 8'h3D, 8'h00, 1'b0};

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].en, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].clr);
            step();
            check($sformatf("vec%0d.q", i),   q,   vecs[i].exp_q);
            check($sformatf("vec%0d.qb", i),  qb,  ~vecs[i].exp_q);
            check($sformatf("vec%0d.err", i), err, vecs[i].exp_err);
            check($sformatf("vec%0d.chg", i), {7'd0, chg}, {7'd0, vecs[i].exp_chg});
        end

        // err set again, then toggle in T mode and reset mid-cycle
        drive(1'b1, 2'd0, 8'h01, 8'h01, 1'b0);
        step();
        check("pre_rst.err", err, 8'h01);
        drive(1'b1, 2'd3, 8'hFF, 8'h00, 1'b0);
        step();
        check("pre_rst.q", q, 8'hC2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst.q",   q,   8'hA5);
        check("mid_rst.qb",  qb,  8'h5A);
        check("mid_rst.err", err, 8'h00);
        check("mid_rst.chg", {7'd0, chg}, 8'h00);
        step();
        check("mid_rst_hold.q", q, 8'hA5);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst.q",   q,   8'h5A);
        check("post_rst.chg", {7'd0, chg}, 8'h01);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                  8'($urandom), 8'($urandom), ($urandom_range(0, 9) == 0));
            step();
            check_model($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
